stream_fifo: RTL
================

# stream_fifo

Synchronous first-in-first-out buffer for a 32-bit valid/ready stream with no combinational path between its two sides. It sits between a stream producer and the consumer interface (`data`/`valid`/`ready` bundle) and absorbs backpressure. It also breaks the ready path between the two sides. Used wherever a port of that interface crosses a timing-critical boundary.

## Interface

- `WIDTH`, 32, payload width in bits; matches the interface `data` field.
- `DEPTH`, 4, number of entries; power of two, ≥ 2.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  WIDTH  upstream payload.
- `in_valid`  in  1  upstream offers `in_data`.
- `in_ready`  out  1  FIFO accepts a beat this cycle.
- `out_data`  out  WIDTH  head-of-queue payload.
- `out_valid`  out  1  head entry present.
- `out_ready`  in  1  downstream consumes head this cycle.
- `count`  out  $clog2(DEPTH)+1  occupancy; present only with `STREAM_FIFO_COUNT_EN`.

## Operation

- Storage: DEPTH × WIDTH register array, write pointer `wp`, read pointer `rp` (each $clog2(DEPTH) bits), occupancy `occ` (0..DEPTH).
- Push = `in_valid && in_ready`: write `in_data` at `mem[wp]`, `wp` increments modulo DEPTH.
- Pop = `out_valid && out_ready`: `rp` increments modulo DEPTH.
- `occ` next value: +1 on push only, −1 on pop only, unchanged on both or neither.
- `in_ready = !rst && (occ != DEPTH)`. It depends only on registered state, never on `out_ready`. A full FIFO refuses a push even when a pop happens in the same cycle.
- `out_valid = (occ != 0)`. `out_data = mem[rp]` when `out_valid`, else all zeros.
- Pointer wrap: `DEPTH−1` increments to 0 with no gap or duplicate beat.
- Order is preserved strictly; no beat is dropped or duplicated.
- Holding rule: while `out_valid && !out_ready`, `out_data` stays stable and `out_valid` stays 1.
- Upstream may deassert `in_valid` at any time. The FIFO places no stability requirement on upstream.
- Storage array is not reset; only pointers and `occ` are.

## Timing

- Reset, asserted for ≥ 1 cycle: during reset `in_ready=0`, `out_valid=0`, `out_data=0`, `count=0`.
- On the first cycle after `rst` falls: `in_ready=1`, `out_valid=0`.
- Reset mid-operation discards all stored beats on the next edge. In-flight handshakes in the reset cycle are ignored.
- Latency: a beat pushed at edge N is visible on `out_valid`/`out_data` after edge N (cycle N+1). Minimum 1 cycle, no fall-through.
- Throughput: one beat per cycle sustained when `out_ready` stays high and occupancy is between 1 and DEPTH−1.
- Full: `in_ready` reasserts in the cycle after the pop edge.
- Empty: `out_valid` reasserts in the cycle after the push edge.

## Configuration

- Macro: `STREAM_FIFO_COUNT_EN`.
- Defined: port `count` exists and is driven combinationally from registered `occ` (0..DEPTH). Reset value is 0.
- Undefined: `count` port is absent. Behaviour of all other ports is identical.

## Test plan

- Reset/idle: hold `rst` for 2 cycles with `in_valid=1`, then release. Required: `in_ready=0` and `out_valid=0` during reset; `in_ready=1` and `out_valid=0` in the first cycle after. No beat is stored from the reset cycles.
- Single beat: push `0xDEADBEEF` at edge N with `out_ready=1`. Required: `out_valid=1` and `out_data=0xDEADBEEF` in cycle N+1; `out_valid=0` after the pop edge; `count` reads 1, then 0.
- Fill and full: push `0x1`–`0x4` with `out_ready=0`. Required: `in_ready=0` and `count=4`. A fifth offer `0x5` is not accepted even if `out_ready` rises in the same cycle. Draining yields 1, 2, 3, 4, then 5 once it is re-offered.
- Wrap and stream: 20 consecutive beats `0x100`–`0x113` with `out_ready=1` continuously. Required: output matches in order, one per cycle after 1-cycle latency, with no bubble across pointer wrap.
- Backpressure hold: with 2 beats stored (`0xA`, `0xB`), hold `out_ready=0` for 5 cycles. Required: `out_data=0xA` is stable throughout, then `0xA` and `0xB` are delivered.
- Mid-operation reset: with 3 beats stored, assert `rst` for 1 cycle. Required: `out_valid=0`, `count=0`, and the first post-reset push is the first beat out.

Source files
------------

// File: rtl/stream_fifo.sv
// Registered valid/ready FIFO, DEPTH x WIDTH; optional occupancy port via STREAM_FIFO_COUNT_EN.
// Latency: 1 cycle push-to-head, no fall-through; sustains one beat per cycle.
// Backpressure: in_ready depends only on registered occupancy, so no ready path crosses the FIFO.
module stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef STREAM_FIFO_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0]   count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      occ;
  logic             push;
  logic             pop;

  // Both sides are masked during reset so handshakes in that cycle are ignored.
  assign in_ready  = !rst && (occ != OCC_FULL);
  assign out_valid = !rst && (occ != '0);
  assign out_data  = out_valid ? mem[rp] : '0;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

`ifdef STREAM_FIFO_COUNT_EN
  assign count = rst ? '0 : occ;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked solely by occ.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= in_data;
  end

endmodule
